// File: rtl/zbus_master.sv
// ZX-bus master cycle generator: turns one request/ack transaction into a Z80-style
// I/O or memory read/write cycle with programmable setup/strobe/hold and wait timeout.
module zbus_master #(
    parameter int unsigned SETUP_CLK  = 1,
    parameter int unsigned STROBE_CLK = 2,
    parameter int unsigned HOLD_CLK   = 1,
    parameter int unsigned WAIT_TMO   = 255
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_io,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        err,
    output logic [15:0] za,
    output logic [7:0]  zd_out,
    output logic        zd_oe,
    input  logic [7:0]  zd_in,
    output logic        ziorq_n,
    output logic        zmreq_n,
    output logic        zrd_n,
    output logic        zwr_n,
    input  logic        zwait_n
);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    localparam logic [3:0] SetupLd  = 4'(SETUP_CLK - 1);
    localparam logic [3:0] StrobeLd = 4'(STROBE_CLK - 1);
    localparam logic [3:0] HoldLd   = 4'(HOLD_CLK - 1);
    localparam logic [7:0] WaitMax  = 8'(WAIT_TMO);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        io_q, io_d;
    logic        wr_q, wr_d;
    logic [15:0] za_q, za_d;
    logic [7:0]  zd_out_q, zd_out_d;
    logic        zd_oe_q, zd_oe_d;
    logic        iorq_n_q, iorq_n_d;
    logic        mreq_n_q, mreq_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        wait_meta_q;
    logic        wait_sync_q;
    logic        wait_s;

    assign wait_s = ~wait_sync_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        io_d     = io_q;
        wr_d     = wr_q;
        za_d     = za_q;
        zd_out_d = zd_out_q;
        zd_oe_d  = zd_oe_q;
        iorq_n_d = iorq_n_q;
        mreq_n_d = mreq_n_q;
        rd_n_d   = rd_n_q;
        wr_n_d   = wr_n_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    io_d     = req_io;
                    wr_d     = req_wr;
                    za_d     = req_addr;
                    zd_out_d = req_wr ? req_wdata : zd_out_q;
                    zd_oe_d  = req_wr;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = SetupLd;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == 4'd0) begin
                    state_d  = StStrobe;
                    cnt_d    = StrobeLd;
                    wcnt_d   = 8'd0;
                    iorq_n_d = ~io_q;
                    mreq_n_d = io_q;
                    rd_n_d   = wr_q;
                    wr_n_d   = ~wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StStrobe: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!wait_s || (wcnt_q == WaitMax)) begin
                    // Exit is reached with wait still active only on timeout
                    err_d    = wait_s;
                    rdata_d  = wr_q ? rdata_q : zd_in;
                    iorq_n_d = 1'b1;
                    mreq_n_d = 1'b1;
                    rd_n_d   = 1'b1;
                    wr_n_d   = 1'b1;
                    cnt_d    = HoldLd;
                    state_d  = StHold;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            StHold: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    zd_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            wcnt_q      <= 8'd0;
            io_q        <= 1'b0;
            wr_q        <= 1'b0;
            za_q        <= 16'd0;
            zd_out_q    <= 8'd0;
            zd_oe_q     <= 1'b0;
            iorq_n_q    <= 1'b1;
            mreq_n_q    <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= 8'd0;
            err_q       <= 1'b0;
            wait_meta_q <= 1'b1;
            wait_sync_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            io_q        <= io_d;
            wr_q        <= wr_d;
            za_q        <= za_d;
            zd_out_q    <= zd_out_d;
            zd_oe_q     <= zd_oe_d;
            iorq_n_q    <= iorq_n_d;
            mreq_n_q    <= mreq_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            wait_meta_q <= zwait_n;
            wait_sync_q <= wait_meta_q;
        end
    end

    assign busy    = busy_q;
    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign za      = za_q;
    assign zd_out  = zd_out_q;
    assign zd_oe   = zd_oe_q;
    assign ziorq_n = iorq_n_q;
    assign zmreq_n = mreq_n_q;
    assign zrd_n   = rd_n_q;
    assign zwr_n   = wr_n_q;

endmodule

// File: tb/tb_zbus_master.sv
// Directed bench for zbus_master: a default-parameter instance (a) and a WAIT_TMO=4
// instance (b); per-cycle samples after acceptance are compared as cycle bitmasks.
module tb_zbus_master;

    logic        fclk;
    logic        rst_n;
    logic        req_a, req_b;
    logic        req_io, req_wr;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [7:0]  zd_in;
    logic        zwait_a, zwait_b;

    logic        a_busy, a_ack, a_err, a_zd_oe, a_ziorq_n, a_zmreq_n, a_zrd_n, a_zwr_n;
    logic [7:0]  a_rdata, a_zd_out;
    logic [15:0] a_za;
    logic        b_busy, b_ack, b_err, b_zd_oe, b_ziorq_n, b_zmreq_n, b_zrd_n, b_zwr_n;
    logic [7:0]  b_rdata, b_zd_out;
    logic [15:0] b_za;

    int n_checks = 0;
    int n_fail   = 0;

    logic        nxt_wr;
    logic [15:0] nxt_addr;

    typedef struct packed {
        logic        iorq_n, mreq_n, rd_n, wr_n, oe, ack, busy, err;
        logic [15:0] za;
        logic [7:0]  zd_out, rdata;
    } smp_t;
    smp_t smp [0:31];

    localparam int FIorq = 0, FMreq = 1, FRd = 2, FWr = 3, FOe = 4;
    localparam int FAck = 5, FBusy = 6, FZa = 7, FZd = 8;

    zbus_master dut_a (
        .fclk(fclk), .rst_n(rst_n), .req(req_a), .req_io(req_io), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(a_busy), .ack(a_ack),
        .rdata(a_rdata), .err(a_err), .za(a_za), .zd_out(a_zd_out), .zd_oe(a_zd_oe),
        .zd_in(zd_in), .ziorq_n(a_ziorq_n), .zmreq_n(a_zmreq_n), .zrd_n(a_zrd_n),
        .zwr_n(a_zwr_n), .zwait_n(zwait_a)
    );

    zbus_master #(.WAIT_TMO(4)) dut_b (
        .fclk(fclk), .rst_n(rst_n), .req(req_b), .req_io(req_io), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(b_busy), .ack(b_ack),
        .rdata(b_rdata), .err(b_err), .za(b_za), .zd_out(b_zd_out), .zd_oe(b_zd_oe),
        .zd_in(zd_in), .ziorq_n(b_ziorq_n), .zmreq_n(b_zmreq_n), .zrd_n(b_zrd_n),
        .zwr_n(b_zwr_n), .zwait_n(zwait_b)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic smp_t grab(input bit b);
        smp_t s;
        s.iorq_n = b ? b_ziorq_n : a_ziorq_n;
        s.mreq_n = b ? b_zmreq_n : a_zmreq_n;
        s.rd_n   = b ? b_zrd_n   : a_zrd_n;
        s.wr_n   = b ? b_zwr_n   : a_zwr_n;
        s.oe     = b ? b_zd_oe   : a_zd_oe;
        s.ack    = b ? b_ack     : a_ack;
        s.busy   = b ? b_busy    : a_busy;
        s.err    = b ? b_err     : a_err;
        s.za     = b ? b_za      : a_za;
        s.zd_out = b ? b_zd_out  : a_zd_out;
        s.rdata  = b ? b_rdata   : a_rdata;
        return s;
    endfunction

    // Bit k set when the field condition holds in cycle k (cycle 1 = first after acceptance)
    function automatic logic [31:0] mask(input int f, input logic [15:0] val, input int lo,
                                         input int hi);
        logic [31:0] m;
        logic        v;
        m = '0;
        for (int k = lo; k <= hi; k++) begin
            case (f)
                FIorq:   v = ~smp[k].iorq_n;
                FMreq:   v = ~smp[k].mreq_n;
                FRd:     v = ~smp[k].rd_n;
                FWr:     v = ~smp[k].wr_n;
                FOe:     v = smp[k].oe;
                FAck:    v = smp[k].ack;
                FBusy:   v = smp[k].busy;
                FZa:     v = (smp[k].za == val);
                FZd:     v = (smp[k].zd_out == val[7:0]);
                default: v = 1'b0;
            endcase
            m[k] = v;
        end
        return m;
    endfunction

    // Called at posedge+1; zwait low for cycles wlo..whi, req dropped from cycle req_off on
    task automatic run_txn(input bit b, input bit io, input bit wr, input logic [15:0] addr,
                           input logic [7:0] wd, input int n, input int wlo, input int whi,
                           input logic [7:0] din, input bit ramp, input int req_off);
        req_io    = io;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        if (b) req_b = 1'b1;
        else   req_a = 1'b1;
        @(posedge fclk);
        #1;
        for (int k = 1; k <= n; k++) begin
            if (k == 1 && req_off > 1) begin
                req_wr   = nxt_wr;
                req_addr = nxt_addr;
            end
            if (k >= req_off) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            if (b) zwait_b = !(k >= wlo && k <= whi);
            else   zwait_a = !(k >= wlo && k <= whi);
            zd_in = ramp ? din + 8'(k) : din;
            @(negedge fclk);
            smp[k] = grab(b);
            @(posedge fclk);
            #1;
        end
        zwait_a = 1'b1;
        zwait_b = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bus"}, 32'({a_za, a_zd_out, a_zd_oe, a_ziorq_n, a_zmreq_n, a_zrd_n,
                                  a_zwr_n}), 32'({16'h0, 8'h0, 1'b0, 4'hF}));
        check({tag, "_ctl"}, 32'({a_busy, a_ack, a_rdata, a_err}), 32'h0);
    endtask

    initial begin
        logic acc;
        rst_n     = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        req_io    = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 8'h0;
        zd_in     = 8'h0;
        zwait_a   = 1'b1;
        zwait_b   = 1'b1;
        nxt_wr    = 1'b0;
        nxt_addr  = 16'h0;
        #22 rst_n = 1'b1;
        @(negedge fclk);
        check_reset_vals("reset");
        check("reset_b_ctl", 32'({b_busy, b_ack, b_ziorq_n, b_zmreq_n, b_zd_oe}), 32'h6);
        @(posedge fclk);
        #1;

        // I/O write 0x80AB <- 0x5A
        run_txn(1'b0, 1'b1, 1'b1, 16'h80AB, 8'h5A, 6, 0, -1, 8'h00, 1'b0, 1);
        check("iowr_iorq", mask(FIorq, 0, 1, 6), 32'h0C);
        check("iowr_wr", mask(FWr, 0, 1, 6), 32'h0C);
        check("iowr_rd_mreq", mask(FRd, 0, 1, 6) | mask(FMreq, 0, 1, 6), 32'h0);
        check("iowr_oe", mask(FOe, 0, 1, 6), 32'h1E);
        check("iowr_za", mask(FZa, 16'h80AB, 1, 4), 32'h1E);
        check("iowr_zd", mask(FZd, 16'h005A, 1, 4), 32'h1E);
        check("iowr_ack", mask(FAck, 0, 1, 6), 32'h20);
        check("iowr_busy", mask(FBusy, 0, 1, 6), 32'h1E);
        check("iowr_err", 32'(smp[5].err), 32'h0);

        // Memory read 0x4000, bus data 0xC3
        run_txn(1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 6, 0, -1, 8'hC3, 1'b0, 1);
        check("mrd_mreq", mask(FMreq, 0, 1, 6), 32'h0C);
        check("mrd_rd", mask(FRd, 0, 1, 6), 32'h0C);
        check("mrd_iorq_wr", mask(FIorq, 0, 1, 6) | mask(FWr, 0, 1, 6), 32'h0);
        check("mrd_oe", mask(FOe, 0, 1, 6), 32'h0);
        check("mrd_za", mask(FZa, 16'h4000, 1, 4), 32'h1E);
        check("mrd_ack", mask(FAck, 0, 1, 6), 32'h20);
        check("mrd_rdata", 32'(smp[5].rdata), 32'hC3);

        // I/O read with zwait_n low cycles 1..5: wait_s seen cycles 3..7, exit edge ends cycle 8
        run_txn(1'b0, 1'b1, 1'b0, 16'h00FE, 8'h00, 11, 1, 5, 8'h10, 1'b1, 1);
        check("wait_iorq", mask(FIorq, 0, 1, 11), 32'h1FC);
        check("wait_rd", mask(FRd, 0, 1, 11), 32'h1FC);
        check("wait_ack", mask(FAck, 0, 1, 11), 32'h400);
        check("wait_rdata", 32'(smp[10].rdata), 32'h18);
        check("wait_err", 32'(smp[10].err), 32'h0);
        check("wait_oe", mask(FOe, 0, 1, 11), 32'h0);

        // WAIT_TMO=4, zwait_n stuck low: strobes low 2+4 cycles, exit edge ends cycle 7
        run_txn(1'b1, 1'b1, 1'b0, 16'h00FF, 8'h00, 10, 1, 99, 8'h20, 1'b1, 1);
        check("tmo_iorq", mask(FIorq, 0, 1, 10), 32'hFC);
        check("tmo_rd", mask(FRd, 0, 1, 10), 32'hFC);
        check("tmo_ack", mask(FAck, 0, 1, 10), 32'h200);
        check("tmo_busy", mask(FBusy, 0, 1, 10), 32'h1FE);
        check("tmo_err_ack", 32'(smp[9].err), 32'h1);
        check("tmo_err_held", 32'(smp[10].err), 32'h1);
        check("tmo_rdata", 32'(smp[9].rdata), 32'h27);

        run_txn(1'b1, 1'b0, 1'b1, 16'h1111, 8'h33, 6, 0, -1, 8'h00, 1'b0, 1);
        check("tmo_err_clr", 32'(smp[1].err), 32'h0);
        check("tmo_next_mreq", mask(FMreq, 0, 1, 6), 32'h0C);
        check("tmo_next_ack", mask(FAck, 0, 1, 6), 32'h20);

        // Back-to-back: write 0x0100 then read 0x0200 accepted in the ack cycle (cycle 5)
        nxt_wr   = 1'b0;
        nxt_addr = 16'h0200;
        run_txn(1'b0, 1'b1, 1'b1, 16'h0100, 8'h77, 11, 0, -1, 8'h40, 1'b1, 6);
        check("b2b_iorq", mask(FIorq, 0, 1, 11), 32'h18C);
        check("b2b_wr", mask(FWr, 0, 1, 11), 32'h0C);
        check("b2b_rd", mask(FRd, 0, 1, 11), 32'h180);
        check("b2b_ack", mask(FAck, 0, 1, 11), 32'h420);
        check("b2b_busy", mask(FBusy, 0, 1, 10), 32'h3DE);
        check("b2b_oe", mask(FOe, 0, 1, 11), 32'h1E);
        check("b2b_za1", mask(FZa, 16'h0100, 1, 4), 32'h1E);
        check("b2b_za2", mask(FZa, 16'h0200, 6, 9), 32'h3C0);
        // Strobe-high gap spans HOLD, the IDLE/ack cycle and SETUP
        check("b2b_gap", mask(FIorq, 0, 4, 6), 32'h0);
        check("b2b_rdata", 32'(smp[10].rdata), 32'h48);

        // Asynchronous reset during STROBE of a write
        req_io    = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h1234;
        req_wdata = 8'hA5;
        req_a     = 1'b1;
        @(posedge fclk);
        #1 req_a = 1'b0;
        @(posedge fclk);
        #2;
        check("rst_pre", 32'({a_ziorq_n, a_zwr_n, a_zd_oe}), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_async_strb", 32'({a_ziorq_n, a_zmreq_n, a_zrd_n, a_zwr_n}), 32'hF);
        check("rst_async_oe", 32'(a_zd_oe), 32'h0);
        acc = 1'b0;
        repeat (2) begin
            @(negedge fclk);
            acc = acc | a_ack;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge fclk);
            acc = acc | a_ack | ~a_ziorq_n | ~a_zwr_n;
        end
        check("rst_no_ack", 32'(acc), 32'h0);
        check_reset_vals("rst_after");
        @(posedge fclk);
        #1;
        run_txn(1'b0, 1'b0, 1'b0, 16'h0042, 8'h00, 6, 0, -1, 8'h99, 1'b0, 1);
        check("rst_idle_ack", mask(FAck, 0, 1, 6), 32'h20);
        check("rst_idle_rdata", 32'(smp[5].rdata), 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
